// File: rtl/tug_key_conditioner.sv
// Two-channel pushbutton front end for the tug-of-war light chain: synchronize,
// debounce and one-shot each key so a physical press yields exactly one pulse.
module tug_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic Clock,
  input  logic reset,
  input  logic key_l_raw,
  input  logic key_r_raw,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic l_held,
  output logic r_held
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
    $error("tug_key_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_e;

  logic [1:0] key_raw;
  logic [1:0] p_raw;
  logic [1:0] pulse;
  logic [1:0] held;

  assign key_raw = {key_r_raw, key_l_raw};
  assign p_raw   = ACTIVE_LOW ? ~key_raw : key_raw;

  // Channel 0 is left, channel 1 is right; no arbitration between them.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic          s1_q, s2_q;
    logic          pulse_q, pulse_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        s1_q    <= p_raw[g];
        s2_q    <= s1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            // Freeze is only looked at here, so a frozen press is consumed.
            state_d = HELD;
            cnt_d   = '0;
            pulse_d = ~freeze;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!s2_q) begin
            state_d = REL_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        REL_WAIT: begin
          if (s2_q) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign pulse[g] = pulse_q;
    assign held[g]  = (state_q == HELD) || (state_q == REL_WAIT);
  end

  assign L      = pulse[0];
  assign R      = pulse[1];
  assign l_held = held[0];
  assign r_held = held[1];

endmodule

// File: tb/tb_tug_key_conditioner.sv
// Bench for tug_key_conditioner: directed scenarios plus random key traffic,
// checked every cycle against a run-length debounce model.
module tb_tug_key_conditioner;

  localparam int D = 4;

  logic Clock = 1'b0;
  logic reset = 1'b0;
  logic freeze = 1'b0;
  logic pl = 1'b0;  // left pressed (logical)
  logic pr = 1'b0;  // right pressed (logical)
  logic key_l_raw, key_r_raw;
  logic L, R, l_held, r_held;

  assign key_l_raw = ~pl;  // active-low buttons
  assign key_r_raw = ~pr;

  tug_key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .Clock    (Clock),
    .reset    (reset),
    .key_l_raw(key_l_raw),
    .key_r_raw(key_r_raw),
    .freeze   (freeze),
    .L        (L),
    .R        (R),
    .l_held   (l_held),
    .r_held   (r_held)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two-sample delay line, then a debounced level that flips
  // once the synchronized input has disagreed with it for D samples in a row.
  logic m_s1[2], m_s2[2], m_lvl[2], m_pulse[2];
  int   m_run[2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pulse[c] = 0; m_run[c] = 0;
    end
  endtask

  task automatic model_step();
    logic raw[2];
    logic p;
    raw[0] = pl;
    raw[1] = pr;
    for (int c = 0; c < 2; c++) begin
      p = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
      m_pulse[c] = 0;
      if (p != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_lvl[c] = p;
          m_run[c] = 0;
          m_pulse[c] = p & ~freeze;
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  int cyc = 0;
  int nl = 0, nr = 0, nlr = 0, first_l = -1;

  task automatic clear_counts();
    cyc = 0; nl = 0; nr = 0; nlr = 0; first_l = -1;
  endtask

  task automatic check_outputs();
    chk("L", int'(L), int'(m_pulse[0]));
    chk("R", int'(R), int'(m_pulse[1]));
    chk("l_held", int'(l_held), int'(m_lvl[0]));
    chk("r_held", int'(r_held), int'(m_lvl[1]));
  endtask

  task automatic cycle();
    @(posedge Clock);
    if (reset) model_reset();
    else model_step();
    #1;
    check_outputs();
    if (L === 1'b1) begin
      nl++;
      if (first_l < 0) first_l = cyc;
    end
    if (R === 1'b1) nr++;
    if (L === 1'b1 && R === 1'b1) nlr++;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called at posedge+1: assert reset mid-cycle, check outputs drop at once.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_L"}, int'(L), 0);
    chk({tag, "_R"}, int'(R), 0);
    chk({tag, "_lheld"}, int'(l_held), 0);
    chk({tag, "_rheld"}, int'(r_held), 0);
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    reset = 1'b1;
    #2;
    chk("rst_L", int'(L), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_lheld", int'(l_held), 0);
    chk("rst_rheld", int'(r_held), 0);
    run(2);
    reset = 1'b0;
    run(3);

    // 1: long left press -> single pulse D+1 edges after first capture
    pl = 1'b1;
    clear_counts();
    run(20);
    chk("t1_pulses", nl, 1);
    chk("t1_latency", first_l, D + 1);
    chk("t1_held", int'(l_held), 1);
    pl = 1'b0;
    run(10);
    chk("t1_released", int'(l_held), 0);

    // 2: right key chatters, then settles pressed
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      pr = (i % 2 == 0);
      cycle();
    end
    chk("t2_bounce", nr, 0);
    pr = 1'b1;
    clear_counts();
    run(10);
    chk("t2_settled", nr, 1);
    pr = 1'b0;
    run(10);

    // 3: simultaneous presses
    pl = 1'b1; pr = 1'b1;
    clear_counts();
    run(10);
    chk("t3_same_cycle", nlr, 1);
    pl = 1'b0; pr = 1'b0;
    run(10);

    // 4: press accepted under freeze is consumed
    freeze = 1'b1;
    pl = 1'b1;
    clear_counts();
    run(8);
    freeze = 1'b0;
    run(10);
    chk("t4_frozen", nl, 0);
    pl = 1'b0;
    run(10);
    pl = 1'b1;
    clear_counts();
    run(10);
    chk("t4_after", nl, 1);
    pl = 1'b0;
    run(10);

    // 5: async reset during PRESS_WAIT and during HELD
    pl = 1'b1;
    run(3);
    async_reset("t5_pw");
    clear_counts();
    run(10);
    chk("t5_pw_pulses", nl, 1);
    async_reset("t5_held");
    clear_counts();
    run(10);
    chk("t5_held_pulses", nl, 1);
    pl = 1'b0;
    run(10);

    // 6: five quick press/release cycles
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      pl = 1'b1; run(6);
      pl = 1'b0; run(6);
    end
    run(4);
    chk("t6_pulses", nl, 5);

    // Random traffic on both keys, freeze and occasional async reset
    for (int i = 0; i < 400; i++) begin
      pl = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      freeze = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
      run(int'($urandom_range(1, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
